// File: rtl/exec_pkg.sv
// exec_pkg: encodings shared by ALU control and the execute stage.
//   ALU op codes, shifter op codes, functional-unit select codes and the
//   execute-stage state enum.
package exec_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_BGEZ = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [3:0] SH_SLL  = 4'b0000;
  localparam logic [3:0] SH_SRL  = 4'b0001;
  localparam logic [3:0] SH_SLLV = 4'b0010;
  localparam logic [3:0] SH_SRLV = 4'b0011;

  localparam logic [1:0] FU_ALU   = 2'b00;
  localparam logic [1:0] FU_SHIFT = 2'b01;
  localparam logic [1:0] FU_LUI   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/exec_unit_alu_comb.sv
// alu_comb: single-cycle combinational ALU.
//   op       - 4-bit ALU operation code
//   a, b     - operands
//   result   - operation result (0 for unknown codes)
//   overflow - signed overflow, add/sub only
module alu_comb
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              add_ovf;
  logic              sub_ovf;

  assign sum  = a + b;
  assign diff = a - b;
  assign add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  assign sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum;
        overflow = add_ovf;
      end
      ALU_SUB: begin
        result   = diff;
        overflow = sub_ovf;
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_NOR:  result = ~(a | b);
      // Sign of the difference corrected by overflow gives the true ordering.
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, diff[DATA_W-1] ^ sub_ovf};
      ALU_BGEZ: result = {{(DATA_W-1){1'b0}}, a[DATA_W-1]};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage with valid/ready handshake on both sides.
//   clk_i, rst_i                - clock, synchronous active-high reset
//   in_valid_i / in_ready_o     - operation handshake
//   alu_op_i, fu_sel_i          - decoded op and unit select from ALU control
//   src1_i, src2_i, shamt_i     - operands
//   out_valid_o / out_ready_i   - result handshake
//   result_o, zero_o, overflow_o - registered result and flags
//
// state | meaning
// IDLE  | ready for a new operation
// SHIFT | iterative shifter running, one bit per cycle
// DONE  | result held until the consumer takes it
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        alu_op_i,
  input  logic [1:0]        fu_sel_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        shamt_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              overflow_o
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [4:0]        count_q, count_d;
  logic              left_q, left_d;
  logic              overflow_q, overflow_d;
  logic              zero_q;
  logic              accept;
  logic [4:0]        cnt_init;
  logic [DATA_W-1:0] data_shifted;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  alu_comb #(.DATA_W(DATA_W)) u_alu (
    .op       (alu_op_i),
    .a        (src1_i),
    .b        (src2_i),
    .result   (alu_res),
    .overflow (alu_ovf)
  );

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign accept      = in_valid_i & in_ready_o;

  // Variable shifts take their amount from rs, immediate shifts from shamt.
  assign cnt_init = alu_op_i[1] ? src1_i[4:0] : shamt_i;

  assign data_shifted = left_q ? {data_q[DATA_W-2:0], 1'b0}
                               : {1'b0, data_q[DATA_W-1:1]};

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    count_d    = count_q;
    left_d     = left_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          overflow_d = 1'b0;
          state_d    = ST_DONE;
          case (fu_sel_i)
            FU_ALU: begin
              result_d   = alu_res;
              overflow_d = alu_ovf;
            end
            FU_SHIFT: begin
              if (alu_op_i[3:2] != 2'b00) begin
                result_d = '0;
              end else if (cnt_init == 5'd0) begin
                result_d = src2_i;
              end else begin
                data_d  = src2_i;
                count_d = cnt_init;
                left_d  = ~alu_op_i[0];
                state_d = ST_SHIFT;
              end
            end
            FU_LUI:  result_d = {src2_i[15:0], {(DATA_W-16){1'b0}}};
            default: result_d = '0;
          endcase
        end
      end
      ST_SHIFT: begin
        data_d  = data_shifted;
        count_d = count_q - 5'd1;
        if (count_q == 5'd1) begin
          result_d = data_shifted;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      count_q    <= '0;
      left_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      count_q    <= count_d;
      left_q     <= left_d;
      result_q   <= result_d;
      zero_q     <= (result_d == '0);
      overflow_q <= overflow_d;
    end
  end

  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [3:0]  alu_op_i = '0;
  logic [1:0]  fu_sel_i = '0;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic [4:0]  shamt_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] result_o;
  logic        zero_o;
  logic        overflow_o;

  exec_unit #(.DATA_W(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .alu_op_i    (alu_op_i),
    .fu_sel_i    (fu_sel_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .shamt_i     (shamt_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .zero_o      (zero_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   busy = 0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops one expectation per result, then checks the held result each DONE cycle.
  always @(negedge clk_i) begin
    if (rst_i || !out_valid_o) begin
      busy = 0;
    end else if (!busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid_o), 32'd0);
        busy = 1;
        cur.res = result_o; cur.zero = zero_o; cur.ovf = overflow_o;
      end else begin
        cur = exp_q.pop_front();
        busy = 1;
        chk("result", result_o, cur.res);
        chk("zero", 32'(zero_o), 32'(cur.zero));
        chk("overflow", 32'(overflow_o), 32'(cur.ovf));
        chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
      end
    end else begin
      chk("held_result", result_o, cur.res);
      chk("held_in_ready", 32'(in_ready_o), 32'd0);
    end
  end

  task automatic issue(input logic [1:0] fu, input logic [3:0] op, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [4:0] sh, input bit push,
                       input logic [31:0] eres, input logic eovf, input int elat);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk_i);
    while (!in_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!in_ready_o) begin
      $display("FAIL issue_timeout: in_ready_o got 0 expected 1");
      n_tot++;
    end
    fu_sel_i = fu; alu_op_i = op; src1_i = s1; src2_i = s2; shamt_i = sh;
    in_valid_i = 1'b1;
    if (push) begin
      e.res = eres; e.zero = (eres == 32'd0); e.ovf = eovf; e.lat = elat; e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
      n_tot++;
    end
  endtask

  initial begin
    int  n;
    bit  saw_ready;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_zero", 32'(zero_o), 32'd1);
    chk("rst_overflow", 32'(overflow_o), 32'd0);

    // ALU vectors: fu, op, src1, src2, shamt, expected result, overflow, latency
    issue(2'b00, 4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0, 1, 32'h80000000, 1'b1, 1);
    issue(2'b00, 4'b0110, 32'd5, 32'd5, 5'd0, 1, 32'h0, 1'b0, 1);
    issue(2'b00, 4'b0110, 32'h80000000, 32'h1, 5'd0, 1, 32'h7FFFFFFF, 1'b1, 1);
    issue(2'b00, 4'b0111, 32'h80000000, 32'h1, 5'd0, 1, 32'h1, 1'b0, 1);
    issue(2'b00, 4'b0111, 32'd5, 32'hFFFFFFFD, 5'd0, 1, 32'h0, 1'b0, 1);
    issue(2'b00, 4'b1001, 32'h0, 32'h0, 5'd0, 1, 32'h0, 1'b0, 1);
    issue(2'b00, 4'b1001, 32'hFFFFFFFF, 32'h0, 5'd0, 1, 32'h1, 1'b0, 1);
    issue(2'b00, 4'b1100, 32'h0, 32'h0, 5'd0, 1, 32'hFFFFFFFF, 1'b0, 1);
    issue(2'b00, 4'b0000, 32'hF0F0FFFF, 32'h0FF0F00F, 5'd0, 1, 32'h00F0F00F, 1'b0, 1);
    issue(2'b00, 4'b0001, 32'hF0000000, 32'h0000000F, 5'd0, 1, 32'hF000000F, 1'b0, 1);
    issue(2'b00, 4'b1111, 32'h12345678, 32'h1, 5'd0, 1, 32'h0, 1'b0, 1);
    issue(2'b11, 4'b0010, 32'h12345678, 32'h1, 5'd0, 1, 32'h0, 1'b0, 1);
    drain();

    // sll by 4: in_ready_o must stay low until the result appears
    issue(2'b01, 4'b0000, 32'h0, 32'h0000000F, 5'd4, 1, 32'h000000F0, 1'b0, 5);
    saw_ready = 0;
    n = 0;
    while (!out_valid_o && n < 50) begin
      if (in_ready_o) saw_ready = 1;
      @(negedge clk_i);
      n++;
    end
    chk("shift_in_ready_low", 32'(saw_ready), 32'd0);
    drain();

    issue(2'b01, 4'b0011, 32'd31, 32'h80000000, 5'd0, 1, 32'h1, 1'b0, 32);
    issue(2'b01, 4'b0000, 32'h0, 32'hDEADBEEF, 5'd0, 1, 32'hDEADBEEF, 1'b0, 1);
    issue(2'b01, 4'b0001, 32'h0, 32'hF0000000, 5'd3, 1, 32'h1E000000, 1'b0, 4);
    issue(2'b01, 4'b0010, 32'hFFFFFFE1, 32'h00000003, 5'd9, 1, 32'h00000006, 1'b0, 2);
    issue(2'b01, 4'b0110, 32'h1, 32'h1, 5'd1, 1, 32'h0, 1'b0, 1);
    drain();

    // Backpressure: result held while junk is presented on the input side
    out_ready_i = 1'b0;
    issue(2'b00, 4'b0010, 32'd3, 32'd4, 5'd0, 1, 32'd7, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid_i = 1'b1;
      fu_sel_i = 2'b00; alu_op_i = 4'b0010;
      src1_i = $urandom; src2_i = $urandom;
      @(negedge clk_i);
    end
    out_ready_i = 1'b1;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("bp_release_in_ready", 32'(in_ready_o), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid_o), 32'd0);
    issue(2'b00, 4'b0110, 32'd10, 32'd3, 5'd0, 1, 32'd7, 1'b0, 1);
    drain();

    // Reset in the middle of a 20-bit shift
    issue(2'b01, 4'b0001, 32'h0, 32'hFFFFFFFF, 5'd20, 0, 32'h0, 1'b0, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst_in_ready", 32'(in_ready_o), 32'd1);
    chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_zero", 32'(zero_o), 32'd1);
    repeat (25) @(negedge clk_i);
    chk("midrst_quiet", 32'(out_valid_o), 32'd0);

    issue(2'b10, 4'b0000, 32'h0, 32'h00001234, 5'd0, 1, 32'h12340000, 1'b0, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time got %0t expected below 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
